button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_chan.sv | 160 ++++++++++++++++
 rtl/button_debounce.sv | 37 +++
 tb/tb_button_debounce.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM states,
// default timing constants (50 MHz clock) and the counter sizing helper.
package debounce_pkg;

  // 20 ms of stable input at 50 MHz before a level change is accepted
  localparam int DEFAULT_STABLE_CYCLES = 1000000;
  // 1 s of continuous hold at 50 MHz before a long-press event
  localparam int DEFAULT_LONG_CYCLES   = 50000000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // Counter width able to hold the larger of the two cycle limits.
  function automatic int counter_width(input int stable_cycles, input int long_cycles);
    int largest;
    largest = (stable_cycles > long_cycles) ? stable_cycles : long_cycles;
    if (largest < 1) begin
      return 1;
    end
    return $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced button channel: two-flop synchronizer, four-state
// qualification FSM, registered press/release strobes.
// Long-press detection is built only when BUTTON_LONG_PRESS_EN is defined;
// otherwise long_press_pulse is tied low and no hold counter exists.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int               CNT_W       = counter_width(STABLE_CYCLES, LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  // The cycle that enters a *_WAIT state already counts as the first stable
  // sample, so the level flips when the incremented count hits this value.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             sample;
  deb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             stable_done;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  // Synchronize the raw pin; preset to released so reset never fakes a press
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], btn_n};
    end
  end

  assign sample      = ~sync_reg[1];
  assign cnt_inc     = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign stable_done = (cnt_inc >= STABLE_LAST);

  // Next-state, stability counter and strobe decisions
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      RELEASED: begin
        cnt_next = '0;
        if (sample) begin
          state_next = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (stable_done) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        cnt_next = '0;
        if (!sample) begin
          state_next = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (sample) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (stable_done) begin
          state_next   = RELEASED;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RELEASED;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign level         = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_FULL = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_reg, hold_next;
  logic             long_reg, long_next;

  // Hold counter: runs in PRESSED, pauses during release bounce, clears otherwise;
  // it parks at LONG_FULL so the strobe fires once per press
  always_comb begin
    hold_next = hold_reg;
    long_next = 1'b0;
    case (state_reg)
      PRESSED: begin
        if (hold_reg != LONG_FULL) begin
          hold_next = hold_reg + CNT_W'(1);
          long_next = (hold_reg == LONG_LAST);
        end
      end
      RELEASE_WAIT: begin
        hold_next = hold_reg;
      end
      default: begin
        hold_next = '0;
      end
    endcase
  end

  // Hold counter and long-press strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      hold_reg <= hold_next;
      long_reg <= long_next;
    end
  end

  assign long_press_pulse = long_reg;
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: replicates debounce_chan once per
// button. Long-press support is enabled by defining BUTTON_LONG_PRESS_EN.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_BUTTONS   = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_n_in,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_press_pulse
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      debounce_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .LONG_CYCLES   (LONG_CYCLES)
      ) u_chan (
        .clk              (clk),
        .reset            (reset),
        .btn_n            (btn_n_in[gi]),
        .level            (btn_level[gi]),
        .press_pulse      (press_pulse[gi]),
        .release_pulse    (release_pulse[gi]),
        .long_press_pulse (long_press_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce (STABLE_CYCLES=4, LONG_CYCLES=16, two buttons).
// A window-based reference model runs alongside directed stimulus.
module tb_button_debounce;

  localparam int NB = 2;
  localparam int S  = 4;
  localparam int L  = 16;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_n_in;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] long_press_pulse;

  button_debounce #(
    .NUM_BUTTONS   (NB),
    .STABLE_CYCLES (S),
    .LONG_CYCLES   (L)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .btn_n_in         (btn_n_in),
    .btn_level        (btn_level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk_vec(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  // Reference model: a channel flips level once the S most recent synchronized
  // samples all disagree with it; a synchronized sample lags the pin by two edges.
  // hist_m bit j holds the pin value captured j+1 edges ago.
  logic [S:0]    hist_m [NB];
  logic [NB-1:0] exp_level, exp_press, exp_release, exp_long;
  int            age_m [NB];

  always @(posedge clk) begin : model
    logic [S-1:0] win;
    logic         rise, fall;
    for (int ch = 0; ch < NB; ch++) begin
      if (reset) begin
        hist_m[ch]      <= '1;
        exp_level[ch]   <= 1'b0;
        exp_press[ch]   <= 1'b0;
        exp_release[ch] <= 1'b0;
        exp_long[ch]    <= 1'b0;
        age_m[ch]       <= 0;
      end else begin
        win  = hist_m[ch][S:1];
        rise = !exp_level[ch] && (win == '0);
        fall = exp_level[ch] && (win == '1);
        hist_m[ch]      <= {hist_m[ch][S-1:0], btn_n_in[ch]};
        exp_level[ch]   <= exp_level[ch] ^ (rise | fall);
        exp_press[ch]   <= rise;
        exp_release[ch] <= fall;
        exp_long[ch]    <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
        if (rise) begin
          age_m[ch] <= 0;
        end else if (exp_level[ch] && !fall && age_m[ch] < L) begin
          age_m[ch] <= age_m[ch] + 1;
          if (age_m[ch] == L - 1) exp_long[ch] <= 1'b1;
        end
`endif
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk_vec("cyc_level",   btn_level,        exp_level);
      chk_vec("cyc_press",   press_pulse,      exp_press);
      chk_vec("cyc_release", release_pulse,    exp_release);
      chk_vec("cyc_long",    long_press_pulse, exp_long);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int nlong, long_at, activity;
  int bounce_pin [4] = '{0, 1, 0, 1};
  int bounce_len [4] = '{3, 1, 3, 12};

  initial begin
    reset    = 1'b1;
    btn_n_in = '1;
    @(negedge clk);
    check_en = 1'b1;
    tick(2);
    chk_vec("reset_level",   btn_level,        2'b00);
    chk_vec("reset_press",   press_pulse,      2'b00);
    chk_vec("reset_release", release_pulse,    2'b00);
    chk_vec("reset_long",    long_press_pulse, 2'b00);
    reset = 1'b0;
    tick(4);
    chk_vec("idle_level", btn_level, 2'b00);
    $display("txn reset/idle done");

    // Clean press on button 0: level rises at edge 6
    btn_n_in[0] = 1'b0;
    tick(5);
    chk_vec("press_e5_level", btn_level, 2'b00);
    tick(1);
    chk_vec("press_e6_level", btn_level, 2'b01);
    chk_vec("press_e6_pulse", press_pulse, 2'b01);
    chk_vec("model_e6_level", exp_level, 2'b01);
    tick(1);
    chk_vec("press_e7_pulse", press_pulse, 2'b00);
    $display("txn clean press ch0");

    // Continue holding to 40 cycles; long press lands 16 edges after the rise
    nlong   = 0;
    long_at = -1;
    for (int i = 8; i <= 40; i++) begin
      tick(1);
      if (long_press_pulse[0]) begin
        nlong++;
        long_at = i;
      end
    end
`ifdef BUTTON_LONG_PRESS_EN
    chk_int("long_count", nlong, 1);
    chk_int("long_edge", long_at, 22);
`else
    chk_int("long_count", nlong, 0);
    chk_int("long_edge", long_at, -1);
`endif
    $display("txn long hold ch0 pulses=%0d at=%0d", nlong, long_at);

    // Clean release on button 0: level falls at edge 6
    btn_n_in[0] = 1'b1;
    tick(5);
    chk_vec("release_e5_level", btn_level, 2'b01);
    tick(1);
    chk_vec("release_e6_level", btn_level, 2'b00);
    chk_vec("release_e6_pulse", release_pulse, 2'b01);
    tick(1);
    chk_vec("release_e7_pulse", release_pulse, 2'b00);
    tick(4);
    $display("txn clean release ch0");

    // Bounce: low 3, high 1, low 3, then high -- never accepted
    activity = 0;
    for (int k = 0; k < 4; k++) begin
      btn_n_in[0] = bounce_pin[k][0];
      for (int c = 0; c < bounce_len[k]; c++) begin
        tick(1);
        if (btn_level[0] || press_pulse[0] || release_pulse[0]) activity++;
      end
    end
    chk_int("bounce_activity", activity, 0);
    $display("txn bounce ch0 activity=%0d", activity);

    // Simultaneous press and release of both buttons
    btn_n_in = 2'b00;
    tick(5);
    chk_vec("simul_e5_press", press_pulse, 2'b00);
    tick(1);
    chk_vec("simul_e6_press", press_pulse, 2'b11);
    chk_vec("simul_e6_level", btn_level, 2'b11);
    tick(1);
    chk_vec("simul_e7_press", press_pulse, 2'b00);
    btn_n_in = 2'b11;
    tick(5);
    chk_vec("simul_rel_e5_level", btn_level, 2'b11);
    tick(1);
    chk_vec("simul_rel_e6_release", release_pulse, 2'b11);
    chk_vec("simul_rel_e6_level", btn_level, 2'b00);
    tick(4);
    $display("txn simultaneous press/release");

    // Button 1 alone leaves button 0 untouched
    btn_n_in[1] = 1'b0;
    tick(6);
    chk_vec("ch1_level", btn_level, 2'b10);
    chk_vec("ch1_press", press_pulse, 2'b10);
    btn_n_in[1] = 1'b1;
    tick(8);
    chk_vec("ch1_rel_level", btn_level, 2'b00);
    $display("txn independent press ch1");

    // Reset while button 0 is mid-count (count 2), button kept held
    btn_n_in[0] = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(2);
    chk_vec("midrst_level", btn_level, 2'b00);
    chk_vec("midrst_press", press_pulse, 2'b00);
    reset = 1'b0;
    tick(5);
    chk_vec("midrst_e5_level", btn_level, 2'b00);
    tick(1);
    chk_vec("midrst_e6_level", btn_level, 2'b01);
    chk_vec("midrst_e6_press", press_pulse, 2'b01);
    chk_vec("model_midrst_level", exp_level, 2'b01);
    btn_n_in[0] = 1'b1;
    tick(8);
    chk_vec("final_level", btn_level, 2'b00);
    $display("txn reset mid-count ch0");

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
